// File: rtl/bit_counter_n.sv
// Parametrised up/down bit counter with load, wrap/saturate mode, registered
// terminal-count compare and sticky overflow/underflow flags.
module bit_counter_n #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TERMINAL = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ClearCounter,
    input  logic             LoadCounter,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             IncCounter,
    input  logic             DecCounter,
    input  logic             ClearFlags,
    output logic [WIDTH-1:0] Count,
    output logic             AtTerminal,
    output logic             Overflow,
    output logic             Underflow
);

    localparam logic [WIDTH-1:0] TERM      = TERMINAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_COUNT = '1;
    localparam logic             TERM_RST  = (TERM == '0);

    logic [WIDTH-1:0] cnt_next;
    logic             ov_next;
    logic             un_next;
    logic [WIDTH-1:0] inc_sum;
    logic [WIDTH-1:0] dec_diff;
    logic             carry;
    logic             borrow;

    assign {carry, inc_sum}   = {1'b0, Count} + {{WIDTH{1'b0}}, 1'b1};
    assign {borrow, dec_diff} = {1'b0, Count} - {{WIDTH{1'b0}}, 1'b1};

    // Flag clear is applied first so that a same-edge overflow/underflow
    // event overrides it.
    always_comb begin
        cnt_next = Count;
        ov_next  = Overflow;
        un_next  = Underflow;
        if (ClearCounter) begin
            cnt_next = '0;
            ov_next  = 1'b0;
            un_next  = 1'b0;
        end else begin
            if (ClearFlags) begin
                ov_next = 1'b0;
                un_next = 1'b0;
            end
            if (LoadCounter) begin
                cnt_next = LoadValue;
            end else if (IncCounter && !DecCounter) begin
                if (carry) begin
                    ov_next  = 1'b1;
                    cnt_next = SATURATE ? MAX_COUNT : inc_sum;
                end else begin
                    cnt_next = inc_sum;
                end
            end else if (DecCounter && !IncCounter) begin
                if (borrow) begin
                    un_next  = 1'b1;
                    cnt_next = SATURATE ? '0 : dec_diff;
                end else begin
                    cnt_next = dec_diff;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Count      <= '0;
            AtTerminal <= TERM_RST;
            Overflow   <= 1'b0;
            Underflow  <= 1'b0;
        end else begin
            Count      <= cnt_next;
            AtTerminal <= (cnt_next == TERM);
            Overflow   <= ov_next;
            Underflow  <= un_next;
        end
    end

endmodule

// File: tb/tb_bit_counter_n.sv
// Bench for bit_counter_n: three configurations driven from shared controls and
// checked against an arithmetic reference model of the counting rules.
module tb_bit_counter_n;

    logic        clk;
    logic        reset;
    logic        clr, ld, inc, dec, clrf;
    logic [31:0] lv;

    logic [7:0]  c8;
    logic [3:0]  c4;
    logic [15:0] c16;
    logic        at8, ov8, un8, at4, ov4, un4, at16, ov16, un16;

    int tests = 0;
    int fails = 0;

    bit_counter_n #(.WIDTH(8), .TERMINAL(8), .SATURATE(1'b0)) u_w8 (
        .clk(clk), .reset(reset), .ClearCounter(clr), .LoadCounter(ld),
        .LoadValue(lv[7:0]), .IncCounter(inc), .DecCounter(dec), .ClearFlags(clrf),
        .Count(c8), .AtTerminal(at8), .Overflow(ov8), .Underflow(un8));

    bit_counter_n #(.WIDTH(4), .TERMINAL(8), .SATURATE(1'b1)) u_w4 (
        .clk(clk), .reset(reset), .ClearCounter(clr), .LoadCounter(ld),
        .LoadValue(lv[3:0]), .IncCounter(inc), .DecCounter(dec), .ClearFlags(clrf),
        .Count(c4), .AtTerminal(at4), .Overflow(ov4), .Underflow(un4));

    bit_counter_n #(.WIDTH(16), .TERMINAL(1000), .SATURATE(1'b0)) u_w16 (
        .clk(clk), .reset(reset), .ClearCounter(clr), .LoadCounter(ld),
        .LoadValue(lv[15:0]), .IncCounter(inc), .DecCounter(dec), .ClearFlags(clrf),
        .Count(c16), .AtTerminal(at16), .Overflow(ov16), .Underflow(un16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one entry per configuration above
    int              mw [3] = '{8, 4, 16};
    bit              ms [3] = '{1'b0, 1'b1, 1'b0};
    longint unsigned mt [3] = '{64'd8, 64'd8, 64'd1000};
    longint unsigned m_cnt [3];
    bit              m_ov  [3];
    bit              m_un  [3];

    logic [31:0] act_cnt [3];
    logic [2:0]  act_fl  [3];
    assign act_cnt[0] = {24'd0, c8};
    assign act_cnt[1] = {28'd0, c4};
    assign act_cnt[2] = {16'd0, c16};
    assign act_fl[0]  = {at8, ov8, un8};
    assign act_fl[1]  = {at4, ov4, un4};
    assign act_fl[2]  = {at16, ov16, un16};

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_ov[i]  = 1'b0;
            m_un[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        longint unsigned mx;
        for (int i = 0; i < 3; i++) begin
            mx = (64'd1 << mw[i]) - 64'd1;
            if (clr) begin
                m_cnt[i] = 0;
                m_ov[i]  = 1'b0;
                m_un[i]  = 1'b0;
            end else begin
                if (clrf) begin
                    m_ov[i] = 1'b0;
                    m_un[i] = 1'b0;
                end
                if (ld) begin
                    m_cnt[i] = longint'(lv) & mx;
                end else if (inc && !dec) begin
                    if (m_cnt[i] == mx) begin
                        m_ov[i] = 1'b1;
                        if (!ms[i]) m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else if (dec && !inc) begin
                    if (m_cnt[i] == 0) begin
                        m_un[i] = 1'b1;
                        if (!ms[i]) m_cnt[i] = mx;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        clr = 0; ld = 0; inc = 0; dec = 0; clrf = 0;
    endtask

    task automatic test_reset();
        tests++;
        if ({c8, at8, ov8, un8} !== 11'd0) begin
            fails++;
            $display("FAIL reset_w8: got cnt=%0d at=%b ov=%b un=%b, expected all 0", c8, at8, ov8, un8);
        end
        tests++;
        if ({c4, at4, ov4, un4, c16, at16, ov16, un16} !== 26'd0) begin
            fails++;
            $display("FAIL reset_w4_w16: got c4=%0d fl=%b c16=%0d fl=%b, expected all 0",
                     c4, {at4, ov4, un4}, c16, {at16, ov16, un16});
        end
        #11 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        idle(); inc = 1;
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (c8 !== 8'd5) begin
            fails++; $display("FAIL count_to_5: got %0d expected 5", c8);
        end
        inc = 0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({c8, at8, ov8, un8} !== 11'd0) begin
            fails++;
            $display("FAIL async_reset: got cnt=%0d at=%b ov=%b un=%b, expected all 0", c8, at8, ov8, un8);
        end
        #1 reset = 1'b1;
        inc = 1;
        for (int i = 0; i < 8; i++) step();
        tests++;
        if (c8 !== 8'd8 || at8 !== 1'b1) begin
            fails++; $display("FAIL terminal_hit: got cnt=%0d at=%b expected 8/1", c8, at8);
        end
        step();
        tests++;
        if (c8 !== 8'd9 || at8 !== 1'b0) begin
            fails++; $display("FAIL terminal_leave: got cnt=%0d at=%b expected 9/0", c8, at8);
        end
        idle();
    endtask

    task automatic test_wrap();
        idle(); lv = 32'd255; ld = 1; step();
        idle(); inc = 1; step();
        tests++;
        if (c8 !== 8'd0 || ov8 !== 1'b1) begin
            fails++; $display("FAIL wrap_inc: got cnt=%0d ov=%b expected 0/1", c8, ov8);
        end
        idle(); dec = 1; step();
        tests++;
        if (c8 !== 8'd255 || un8 !== 1'b1) begin
            fails++; $display("FAIL wrap_dec: got cnt=%0d un=%b expected 255/1", c8, un8);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({ov8, un8} !== 2'b11 || c8 !== 8'd255) begin
                fails++; $display("FAIL flags_sticky: got ov=%b un=%b cnt=%0d expected 1/1/255", ov8, un8, c8);
            end
        end
        clrf = 1; step(); idle();
        tests++;
        if ({ov8, un8} !== 2'b00 || c8 !== 8'd255) begin
            fails++; $display("FAIL clear_flags: got ov=%b un=%b cnt=%0d expected 0/0/255", ov8, un8, c8);
        end
    endtask

    task automatic test_saturate();
        idle(); lv = 32'd15; ld = 1; step();
        idle(); inc = 1;
        for (int i = 0; i < 3; i++) step();
        idle();
        tests++;
        if (c4 !== 4'd15 || ov4 !== 1'b1) begin
            fails++; $display("FAIL sat_high: got cnt=%0d ov=%b expected 15/1", c4, ov4);
        end
        clr = 1; step(); idle();
        dec = 1; step(); idle();
        tests++;
        if (c4 !== 4'd0 || un4 !== 1'b1 || ov4 !== 1'b0) begin
            fails++; $display("FAIL sat_low: got cnt=%0d un=%b ov=%b expected 0/1/0", c4, un4, ov4);
        end
    endtask

    task automatic test_priority();
        idle(); lv = 32'h3C; clr = 1; ld = 1; inc = 1; step();
        tests++;
        if (c8 !== 8'd0) begin
            fails++; $display("FAIL prio_clear: got %0d expected 0", c8);
        end
        clr = 0; step();
        tests++;
        if (c8 !== 8'h3C) begin
            fails++; $display("FAIL prio_load: got %0d expected 60", c8);
        end
        ld = 0; inc = 1; dec = 1; step(); idle();
        tests++;
        if (c8 !== 8'h3C || {ov8, un8} !== 2'b00) begin
            fails++; $display("FAIL prio_incdec: got cnt=%0d ov=%b un=%b expected 60/0/0", c8, ov8, un8);
        end
    endtask

    task automatic test_simultaneous();
        idle(); lv = 32'd255; ld = 1; step();
        idle(); inc = 1; clrf = 1; step();
        tests++;
        if (c8 !== 8'd0 || ov8 !== 1'b1) begin
            fails++; $display("FAIL set_beats_clear: got cnt=%0d ov=%b expected 0/1", c8, ov8);
        end
        inc = 0; step(); idle();
        tests++;
        if (ov8 !== 1'b0) begin
            fails++; $display("FAIL clear_after_set: got ov=%b expected 0", ov8);
        end
    endtask

    task automatic test_sweep();
        idle(); lv = 32'd998; ld = 1; step();
        idle(); inc = 1; step();
        tests++;
        if (c16 !== 16'd999 || at16 !== 1'b0) begin
            fails++; $display("FAIL sweep_999: got cnt=%0d at=%b expected 999/0", c16, at16);
        end
        step();
        tests++;
        if (c16 !== 16'd1000 || at16 !== 1'b1) begin
            fails++; $display("FAIL sweep_1000: got cnt=%0d at=%b expected 1000/1", c16, at16);
        end
        idle(); dec = 1; step(); idle();
        tests++;
        if (c16 !== 16'd999 || at16 !== 1'b0) begin
            fails++; $display("FAIL sweep_back: got cnt=%0d at=%b expected 999/0", c16, at16);
        end
    endtask

    task automatic test_random();
        logic [2:0] exp_fl;
        for (int n = 0; n < 400; n++) begin
            clr  = ($urandom_range(0, 31) == 0);
            ld   = ($urandom_range(0, 9) == 0);
            inc  = $urandom_range(0, 1);
            dec  = ($urandom_range(0, 2) == 0);
            clrf = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       lv = '1;
                1:       lv = '0;
                2:       lv = 32'd997 + $urandom_range(0, 6);
                default: lv = $urandom;
            endcase
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b0;
                model_reset();
                #1 reset = 1'b1;
            end
            step();
            for (int i = 0; i < 3; i++) begin
                exp_fl = {m_cnt[i] == mt[i], m_ov[i], m_un[i]};
                tests++;
                if (act_cnt[i] !== 32'(m_cnt[i]) || act_fl[i] !== exp_fl) begin
                    fails++;
                    $display("FAIL random_w%0d cycle %0d: got cnt=%0d at/ov/un=%b expected cnt=%0d at/ov/un=%b",
                             mw[i], n, act_cnt[i], act_fl[i], m_cnt[i], exp_fl);
                end
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b0;
        lv = '0;
        idle();
        model_reset();
        #1;
        test_reset();
        test_reset_mid();
        test_wrap();
        test_saturate();
        test_priority();
        test_simultaneous();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_counter_n.md
Name: bit_counter_n

Overview:
Parametrised successor to the 8-bit bit counter used by the serial datapath FSMs. It adds a configurable width, up/down counting, parallel load, a selectable wrap or saturate mode, a terminal-count compare and sticky over/underflow flags. Controlling FSMs use it to count received/transmitted bits and detect frame completion without external comparators. All outputs are registered; a command takes effect on the very next clk edge, with no extra pipeline stage.

Parameters:
WIDTH, 8, counter width in bits (2..32)
TERMINAL, 8, compare value driving AtTerminal; must fit in WIDTH bits
SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at 0 and at 2^WIDTH-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
ClearCounter  input  1  synchronous clear of Count and both flags
LoadCounter  input  1  synchronous parallel load from LoadValue
LoadValue  input  WIDTH  value loaded when LoadCounter=1
IncCounter  input  1  count up by 1
DecCounter  input  1  count down by 1
ClearFlags  input  1  clear Overflow/Underflow only; Count unaffected
Count  output  WIDTH  current count, registered
AtTerminal  output  1  registered; 1 when the Count value being presented equals TERMINAL
Overflow  output  1  sticky; set on an increment from 2^WIDTH-1
Underflow  output  1  sticky; set on a decrement from 0

Behaviour:
- reset=0, asynchronous, any time including mid-count: Count=0, Overflow=0, Underflow=0. AtTerminal=1 if TERMINAL==0, else 0. Holds while reset=0. Normal operation resumes on the first clk edge after reset returns to 1.
- Per-edge priority, highest first:
  - ClearCounter: Count <= 0 and both flags <= 0. All other inputs are ignored.
  - LoadCounter: Count <= LoadValue. Flags are unchanged unless ClearFlags=1.
  - IncCounter=1 and DecCounter=1 together: hold. No flag change.
  - IncCounter only: increment.
  - DecCounter only: decrement.
  - None asserted: hold.
- Increment at Count=2^WIDTH-1:
  - SATURATE=0: Count <= 0.
  - SATURATE=1: Count stays at max.
  - Overflow <= 1 in both modes.
- Decrement at Count=0:
  - SATURATE=0: Count <= 2^WIDTH-1.
  - SATURATE=1: Count stays 0.
  - Underflow <= 1 in both modes.
- Flags are sticky until ClearCounter, ClearFlags or reset.
- ClearFlags and a flag-setting event on the same edge: the set wins (flag=1 after the edge).
- ClearFlags together with LoadCounter: flags cleared and load performed.
- AtTerminal is computed from the next-state count and registered, so it is asserted in the same cycle Count shows TERMINAL. There is no lag.
- Arithmetic is unsigned, WIDTH bits. No internal state is wider than WIDTH, apart from the carry/borrow detect.
- No state machine beyond the count register and two flag flops. All outputs change only on a clk edge or on reset assertion.
- Latency: a command on edge N is visible on Count/flags/AtTerminal immediately after edge N.

Test Plan:
- Reset mid-operation, defaults (WIDTH=8, TERMINAL=8): count up to 5, pull reset low between edges -> Count=0, flags=0, AtTerminal=0 immediately with no clk edge. Release reset, then 8 IncCounter cycles -> Count=8 and AtTerminal=1 after the 8th edge; 9th Inc -> Count=9, AtTerminal=0.
- Wrap mode (SATURATE=0): LoadValue=255 with LoadCounter, then one Inc -> Count=0, Overflow=1. Dec -> Count=255, Underflow=1. Both flags stay 1 for 3 idle cycles. ClearFlags -> both 0, Count=255.
- Saturate mode (WIDTH=4, SATURATE=1): load 15, Inc x3 -> Count=15, Overflow=1. ClearCounter, then Dec -> Count=0, Underflow=1.
- Priority: ClearCounter+LoadCounter(LoadValue=0x3C)+Inc on one edge -> Count=0. LoadCounter(0x3C)+Inc -> Count=0x3C. Inc+Dec together at Count=0x3C -> Count=0x3C, no flag change.
- Simultaneous flag events: at Count=255 (SATURATE=0) assert Inc+ClearFlags -> Count=0, Overflow=1. Next edge ClearFlags alone -> Overflow=0.
- Width/terminal sweep: WIDTH=16, TERMINAL=1000; load 998, Inc x2 -> AtTerminal=1 at Count=1000. Dec -> Count=999, AtTerminal=0.
